bias_bank_seq: RTL
==================

Name: bias_bank_seq

Overview:
- Loadable, multi-group successor to the per-layer constant bias blocks.
- Holds N_GROUPS × N_adder_tree signed DATA_W-bit biases, loaded serially at run time instead of hard-coded.
- Presents the active group's biases to the adder-tree lanes, with a group pointer that steps per output-channel group.
- Optionally adds the biases to an incoming accumulator vector with saturation, so one instance serves every layer of the conv pipeline.

Parameters:
N_adder_tree, 16, lanes per group (one bias per adder-tree output)
DATA_W, 18, bias/accumulator width, two's complement
N_GROUPS, 4, bias groups stored (output channels = N_GROUPS*N_adder_tree)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
load_en  in  1  write load_data into the next bias slot this cycle
load_data  in  DATA_W  serial bias word
loaded  out  1  all N_GROUPS*N_adder_tree slots written since last (re)load start
grp_rst  in  1  set group pointer to 0
grp_next  in  1  advance group pointer
grp_idx  out  clog2(N_GROUPS) (min 1)  current group pointer
q  out  N_adder_tree*DATA_W  biases of group grp_idx; lane i at q[DATA_W*(i+1)-1:DATA_W*i]
acc_valid  in  1  acc_in valid this cycle
acc_in  in  N_adder_tree*DATA_W  accumulator vector, same lane packing
sum_valid  out  1  sum_out valid
sum_out  out  N_adder_tree*DATA_W  saturated acc_in + q, registered
err  out  1  sticky: acc_valid seen while not loaded

Behaviour:
- Reset (async, any time incl. mid-load): state EMPTY, write index 0, grp_idx 0, loaded 0, sum_valid 0, sum_out 0, err 0, all bias registers 0 (so q = 0).
- States:
  - EMPTY: load_en -> LOADING.
  - LOADING: the first load_en cycle also writes.
  - READY: entered the cycle after the final slot write.
- Write index k (0..N_GROUPS*N_adder_tree-1) stores into group k/N_adder_tree, lane k%N_adder_tree; index increments per load_en. The final write sets loaded=1 next cycle and returns index to 0.
- load_en deasserted during LOADING: hold index, no write (gaps allowed).
- load_en in READY: starts a reload. Writes slot 0 that cycle, loaded drops to 0 next cycle, state -> LOADING. Unwritten slots keep their old values until overwritten.
- Group pointer:
  - grp_rst sets grp_idx to 0.
  - Else grp_next increments grp_idx, wrapping N_GROUPS-1 -> 0.
  - Both asserted: grp_rst wins.
  - Pointer operates in every state.
- q is a combinational mux of the bias registers by registered grp_idx. It changes the cycle after grp_next, and reflects a slot write the cycle after that write.
- Add path, 1-cycle latency:
  - If acc_valid and loaded: next cycle sum_valid=1 and sum_out lane i = sat(acc_in[i] + bias[grp_idx][i]), using the grp_idx value in the acc_valid cycle. A simultaneous grp_next affects only later beats.
  - Addition is computed at DATA_W+1 bits, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Back-to-back acc_valid gives a sum every cycle.
  - If acc_valid and not loaded: no sum_valid, err set (cleared only by rst).
  - No acc_valid: sum_valid=0, sum_out holds its last value.
- Simultaneous load_en write to group G and acc_valid using group G: the sum uses the pre-write bias value.

Test Plan:
- Reset then load 64 words, word k = k*4 (N=16, W=18, G=4) -> loaded rises the cycle after the 64th write; grp_idx=0; q lane 5 = 20.
- grp_next pulsed 5 times -> grp_idx 1,2,3,0,1; q lane 0 = 64 at group 1. Assert grp_rst with grp_next -> grp_idx 0.
- Group 2 loaded with lane0 = 18'h1FFFF, acc lane0 = 1 -> sum_out lane0 = 18'h1FFFF (positive saturate). Lane0 = 18'h20000 + acc 18'h3FFFF -> 18'h20000 (negative saturate).
- Continuous acc_valid for 4 cycles with grp_next in cycle 2 -> sums 1,2 use group g, sums 3,4 use group g+1; sum_valid high 4 consecutive cycles, 1 cycle delayed.
- acc_valid before loading completes (after 10 writes) -> no sum_valid, err=1 and stays 1 after loading completes.
- Assert rst after 30 writes -> q=0, loaded=0, index restarts; a subsequent full 64-word load succeeds. Separately, load_en in READY -> loaded=0 next cycle.

Source files
------------

// File: rtl/bias_bank_seq.sv
// bias_bank_seq: serially loaded, multi-group bias bank for the conv adder tree.
// Presents the active group's biases and optionally adds them to an accumulator vector.
module bias_bank_seq #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int N_GROUPS     = 4,
    localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    localparam int LW = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_en,
    input  logic [DATA_W-1:0]              load_data,
    output logic                           loaded,
    input  logic                           grp_rst,
    input  logic                           grp_next,
    output logic [GW-1:0]                  grp_idx,
    output logic [N_adder_tree*DATA_W-1:0] q,
    input  logic                           acc_valid,
    input  logic [N_adder_tree*DATA_W-1:0] acc_in,
    output logic                           sum_valid,
    output logic [N_adder_tree*DATA_W-1:0] sum_out,
    output logic                           err
);

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t                     state_q, state_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic [GW-1:0]              wgrp_q, wgrp_d;
    logic [GW-1:0]              grp_q;
    logic [DATA_W-1:0]          bias_q [N_GROUPS][N_adder_tree];
    logic [N_adder_tree*DATA_W-1:0] sum_q, sum_d;
    logic                       sum_valid_q;
    logic                       err_q;
    logic                       last_wr;

    assign last_wr = (lane_q == LW'(N_adder_tree - 1)) &&
                     (wgrp_q == GW'(N_GROUPS - 1));

    assign loaded    = (state_q == READY);
    assign grp_idx   = grp_q;
    assign sum_valid = sum_valid_q;
    assign sum_out   = sum_q;
    assign err       = err_q;

    // Load FSM next state and write-slot (group, lane) advance
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        wgrp_d  = wgrp_q;
        unique case (state_q)
            EMPTY:   if (load_en) state_d = last_wr ? READY : LOADING;
            LOADING: if (load_en && last_wr) state_d = READY;
            READY:   if (load_en) state_d = last_wr ? READY : LOADING;
            default: state_d = EMPTY;
        endcase
        if (load_en) begin
            if (last_wr) begin
                lane_d = '0;
                wgrp_d = '0;
            end else if (lane_q == LW'(N_adder_tree - 1)) begin
                lane_d = '0;
                wgrp_d = wgrp_q + 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    // Load FSM state and write-slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            lane_q  <= '0;
            wgrp_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wgrp_q  <= wgrp_d;
        end
    end

    // Bias storage: one slot written per load_en cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++)
                for (int l = 0; l < N_adder_tree; l++)
                    bias_q[g][l] <= '0;
        end else if (load_en) begin
            bias_q[wgrp_q][lane_q] <= load_data;
        end
    end

    // Group pointer: reset has priority over advance, wraps at N_GROUPS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q <= '0;
        end else if (grp_rst) begin
            grp_q <= '0;
        end else if (grp_next) begin
            grp_q <= (grp_q == GW'(N_GROUPS - 1)) ? '0 : grp_q + 1'b1;
        end
    end

    // Active group's biases muxed onto the lane bus
    always_comb begin
        q = '0;
        for (int i = 0; i < N_adder_tree; i++)
            q[DATA_W*i +: DATA_W] = bias_q[grp_q][i];
    end

    // Per-lane widened add with saturation back to DATA_W
    always_comb begin
        logic [DATA_W:0] ext;
        ext   = '0;
        sum_d = '0;
        for (int i = 0; i < N_adder_tree; i++) begin
            ext = {acc_in[DATA_W*i + DATA_W - 1], acc_in[DATA_W*i +: DATA_W]} +
                  {q[DATA_W*i + DATA_W - 1], q[DATA_W*i +: DATA_W]};
            if (ext[DATA_W] != ext[DATA_W-1])
                sum_d[DATA_W*i +: DATA_W] = ext[DATA_W] ?
                    {1'b1, {(DATA_W-1){1'b0}}} :
                    {1'b0, {(DATA_W-1){1'b1}}};
            else
                sum_d[DATA_W*i +: DATA_W] = ext[DATA_W-1:0];
        end
    end

    // Registered sum output; sum_out holds when no beat is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= acc_valid && loaded;
            if (acc_valid && loaded)
                sum_q <= sum_d;
        end
    end

    // Sticky flag for accumulator beats arriving before the bank is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (acc_valid && !loaded)
            err_q <= 1'b1;
    end

endmodule
